fpu_result_queue: RTL and testbench

FPU_RESULT_QUEUE -- requirements
Module: fpu_result_queue

---
 rtl/fpu_result_queue.sv | 123 ++++++++++++
 tb/tb_fpu_result_queue.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fpu_result_queue.sv
// rtl/fpu_result_queue.sv - result queue between the FP divider and the writeback stage
//
// Holds up to DEPTH divider results in strict FIFO order. Each entry carries the
// result word, its five exception flags and its format bit. Consumed entries fold
// their flags into a sticky fflags register that software clears with flags_clr.
//
// Ports
//   clk          single clock, all state changes on its rising edge
//   rst          synchronous active-high reset; wins over push, pop and flags_clr
//   in_valid     divider result valid
//   in_ready     queue has a free entry (occupancy < DEPTH)
//   in_result    divider result, FP32 or FP16 in [15:0]
//   in_flags     {invalid, overflow, underflow, div_zero, inexact}
//   in_mode_fp   1 = FP32, 0 = FP16
//   out_valid    head entry present
//   out_ready    downstream consumes the head
//   out_result   head result (0 when empty)
//   out_flags    head flags (0 when empty)
//   out_mode_fp  head format (0 when empty)
//   flags_clr    clear accumulated flags
//   fflags       sticky OR of the flags of every consumed result
//   occupancy    number of valid entries

module fpu_result_queue #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_result,
  input  logic [4:0]                 in_flags,
  input  logic                       in_mode_fp,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_result,
  output logic [4:0]                 out_flags,
  output logic                       out_mode_fp,
  input  logic                       flags_clr,
  output logic [4:0]                 fflags,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  logic [31:0]      mem_result [DEPTH];
  logic [4:0]       mem_flags  [DEPTH];
  logic             mem_mode   [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ_q;

  logic             push;
  logic             pop;
  logic [31:0]      store_result;

  // Ready depends on registered occupancy only, so a full queue never accepts
  // a new entry in the same cycle its head is being drained.
  assign in_ready  = (occ_q < FULL_OCC);
  assign out_valid = (occ_q != '0);
  assign occupancy = occ_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // FP16 results keep only the low half; the upper half is forced to zero so
  // stale upper bits from the divider datapath never leak to writeback.
  assign store_result = in_mode_fp ? in_result : {16'h0000, in_result[15:0]};

  // Head outputs are gated so an empty queue presents all-zero data rather
  // than whatever the unreset storage happens to hold.
  assign out_result  = out_valid ? mem_result[rd_ptr] : 32'h0;
  assign out_flags   = out_valid ? mem_flags[rd_ptr]  : 5'h00;
  assign out_mode_fp = out_valid ? mem_mode[rd_ptr]   : 1'b0;

  // Entry storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_result[wr_ptr] <= store_result;
      mem_flags[wr_ptr]  <= in_flags;
      mem_mode[wr_ptr]   <= in_mode_fp;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      case ({push, pop})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Clear acts before the same-cycle accumulation, so a result popped in the
  // clearing cycle is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      fflags <= 5'h00;
    end else if (flags_clr) begin
      fflags <= pop ? out_flags : 5'h00;
    end else if (pop) begin
      fflags <= fflags | out_flags;
    end
  end

endmodule

// File: tb/tb_fpu_result_queue.sv
// tb/tb_fpu_result_queue.sv - self-checking bench for fpu_result_queue

module tb_fpu_result_queue;

  localparam int DEPTH = 2;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_result;
  logic [4:0]       in_flags;
  logic             in_mode_fp;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [4:0]       out_flags;
  logic             out_mode_fp;
  logic             flags_clr;
  logic [4:0]       fflags;
  logic [OCC_W-1:0] occupancy;

  int errors = 0;
  int checks = 0;

  fpu_result_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_flags(in_flags), .in_mode_fp(in_mode_fp),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .out_mode_fp(out_mode_fp),
    .flags_clr(flags_clr), .fflags(fflags), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain list of entries plus a sticky flag word.
  typedef struct {
    logic [31:0] r;
    logic [4:0]  f;
    logic        m;
  } ent_t;

  ent_t       mq[$];
  logic [4:0] m_fflags;
  bit         model_live = 0;

  always @(posedge clk) begin
    bit   do_push, do_pop;
    ent_t e;
    if (rst) begin
      mq.delete();
      m_fflags   = 5'h00;
      model_live = 1;
    end else if (model_live) begin
      do_push = in_valid && (mq.size() < DEPTH);
      do_pop  = out_ready && (mq.size() > 0);
      if (flags_clr)   m_fflags = do_pop ? mq[0].f : 5'h00;
      else if (do_pop) m_fflags = m_fflags | mq[0].f;
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        e.r = in_mode_fp ? in_result : {16'h0000, in_result[15:0]};
        e.f = in_flags;
        e.m = in_mode_fp;
        mq.push_back(e);
      end
    end
    #1;
    if (model_live) begin
      chk("m_in_ready",  32'(in_ready),    32'(mq.size() < DEPTH));
      chk("m_out_valid", 32'(out_valid),   32'(mq.size() != 0));
      chk("m_occupancy", 32'(occupancy),   32'(mq.size()));
      chk("m_fflags",    32'(fflags),      32'(m_fflags));
      chk("m_out_result", out_result,      mq.size() != 0 ? mq[0].r : 32'h0);
      chk("m_out_flags", 32'(out_flags),   mq.size() != 0 ? 32'(mq[0].f) : 32'h0);
      chk("m_out_mode",  32'(out_mode_fp), mq.size() != 0 ? 32'(mq[0].m) : 32'h0);
    end
  end

  // Apply one cycle of inputs; returns at the next falling edge.
  task automatic step(input logic r, input logic iv, input logic [31:0] d,
                      input logic [4:0] f, input logic m, input logic ordy,
                      input logic clr);
    rst = r; in_valid = iv; in_result = d; in_flags = f; in_mode_fp = m;
    out_ready = ordy; flags_clr = clr;
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 32'h0, 5'h0, 1'b0, 0, 0);
  endtask

  initial begin
    rst = 1; in_valid = 0; in_result = 0; in_flags = 0; in_mode_fp = 0;
    out_ready = 0; flags_clr = 0;
    @(negedge clk);
    step(1, 0, 32'h0, 5'h0, 0, 0, 0);
    idle();
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_occ",       32'(occupancy), 32'd0);
    chk("rst_fflags",    32'(fflags),    32'd0);
    chk("rst_result",    out_result,     32'h0);

    // single push, one-cycle latency
    step(0, 1, 32'h3F800000, 5'h00, 1, 0, 0);
    chk("lat_valid",  32'(out_valid), 32'd1);
    chk("lat_result", out_result,     32'h3F800000);
    chk("lat_occ",    32'(occupancy), 32'd1);
    step(0, 0, 32'h0, 5'h0, 0, 1, 0);
    chk("lat_drained", 32'(occupancy), 32'd0);

    // fill, overflow attempt ignored, drain in order
    step(0, 1, 32'h40000000, 5'h00, 1, 0, 0);
    step(0, 1, 32'h40400000, 5'h00, 1, 0, 0);
    chk("full_ready", 32'(in_ready),  32'd0);
    chk("full_occ",   32'(occupancy), 32'd2);
    step(0, 1, 32'hDEADBEEF, 5'h1F, 1, 0, 0);
    chk("full_occ2",  32'(occupancy), 32'd2);
    chk("full_head",  out_result,     32'h40000000);
    step(0, 0, 32'h0, 5'h0, 0, 1, 0);
    chk("pop1", out_result, 32'h40400000);
    step(0, 0, 32'h0, 5'h0, 0, 1, 0);
    chk("pop2_valid",  32'(out_valid), 32'd0);
    chk("pop2_result", out_result,     32'h0);

    // FP16 upper half masking
    step(0, 1, 32'hABCD3C00, 5'h00, 0, 0, 0);
    chk("fp16_result", out_result,       32'h00003C00);
    chk("fp16_mode",   32'(out_mode_fp), 32'd0);
    step(0, 0, 32'h0, 5'h0, 0, 1, 0);

    // sticky flags and clear-with-pop
    step(0, 1, 32'h11111111, 5'b00010, 1, 0, 0);
    step(0, 1, 32'h22222222, 5'b00001, 1, 0, 0);
    chk("push_no_flags", 32'(fflags), 32'd0);
    step(0, 0, 32'h0, 5'h0, 0, 1, 0);
    step(0, 0, 32'h0, 5'h0, 0, 1, 0);
    chk("fflags_or", 32'(fflags), 32'(5'b00011));
    step(0, 1, 32'h33333333, 5'b10000, 1, 0, 0);
    step(0, 0, 32'h0, 5'h0, 0, 1, 1);
    chk("fflags_clr_pop", 32'(fflags), 32'(5'b10000));

    // streaming push+pop across pointer wrap
    step(0, 1, 32'd100, 5'h0, 1, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, 32'd100 + 32'(i), 5'(i), 1, 1, 0);
      chk("stream_occ", 32'(occupancy), 32'd1);
    end
    chk("stream_last", out_result, 32'd108);
    step(0, 0, 32'h0, 5'h0, 0, 1, 0);

    // reset beats push and clear
    step(0, 0, 32'h0, 5'h0, 0, 0, 1);
    step(0, 1, 32'h44444444, 5'b01000, 1, 0, 0);
    step(0, 0, 32'h0, 5'h0, 0, 1, 0);
    step(0, 1, 32'h55555555, 5'h0, 1, 0, 0);
    step(0, 1, 32'h66666666, 5'h0, 1, 0, 0);
    chk("pre_rst_occ",    32'(occupancy), 32'd2);
    chk("pre_rst_fflags", 32'(fflags),    32'(5'b01000));
    step(1, 1, 32'h77777777, 5'h1F, 1, 0, 1);
    chk("rst2_occ",    32'(occupancy), 32'd0);
    chk("rst2_valid",  32'(out_valid), 32'd0);
    chk("rst2_fflags", 32'(fflags),    32'd0);
    chk("rst2_ready",  32'(in_ready),  32'd1);

    // mixed traffic pattern, model-checked every cycle
    for (int i = 0; i < 200; i++) begin
      step(i % 97 == 50, (i % 3) != 0, {i[7:0], 8'h5A, ~i[7:0], i[7:0]},
           5'(i * 7), (i % 4) != 1, (i % 5) < 2, (i % 23) == 11);
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
